mc_control_fsm: RTL

- Multicycle control unit: the producer side of the conditional-execution interface.
- Decodes the instruction register fields and sequences each instruction through a Moore state machine.
- Drives the raw, ungated write requests (PCs, RegW, MemW, FlagW) and the NextPC/Branch strobes into the conditional-logic block, plus all datapath mux selects.
- Sits between the instruction register and the conditional-logic/datapath; one instruction takes 3–5 cycles plus memory stall cycles.

---
 rtl/mc_ctrl_pkg.sv | 73 +++++++
 rtl/mc_control_fsm_if.sv | 52 +++++
 rtl/mc_alu_decoder.sv | 51 +++++
 rtl/mc_control_fsm.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared definitions for the multicycle control unit and its datapath:
//   - state encoding of the control FSM
//   - Op codes (Instr[27:26]) and data-processing cmd codes (Instr[24:21])
//   - ALUControl encoding and the datapath mux-select encodings
//   - cmd_supported(): which data-processing commands the datapath implements
// ---------------------------------------------------------------------------
package mc_ctrl_pkg;

  // Minimum width needed to hold every state below
  localparam int STATE_MIN_W = 4;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  // Instruction class, Instr[27:26]
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // Data-processing commands, Funct[4:1]
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // ALUControl encoding
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Memory address source
  localparam logic ADR_PC     = 1'b0;
  localparam logic ADR_ALUOUT = 1'b1;

  // ALU A operand source
  localparam logic SRCA_RN = 1'b0;
  localparam logic SRCA_PC = 1'b1;

  // ALU B operand source
  localparam logic [1:0] SRCB_RM   = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result bus source
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  // True for the data-processing commands the ALU implements
  function automatic logic cmd_supported(input logic [3:0] cmd);
    logic ok;
    case (cmd)
      CMD_AND, CMD_SUB, CMD_ADD, CMD_ORR: ok = 1'b1;
      default:                            ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mc_control_fsm_if.sv
// ---------------------------------------------------------------------------
// mc_control_fsm_if
// Bundle between the control unit and the instruction register / conditional
// logic / datapath.
//   master (control unit): reads Op, Funct, Rd, mem_ready; drives the raw
//          write requests, PC strobes, mux selects and the illegal pulse.
//   slave  (datapath side): the mirror image.
// ---------------------------------------------------------------------------
interface mc_control_fsm_if;
  import mc_ctrl_pkg::*;

  // Instruction fields and memory handshake
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       mem_ready;

  // Write requests and PC strobes
  logic       IRWrite;
  logic       NextPC;
  logic       Branch;
  logic       PCs;
  logic       RegW;
  logic       MemW;
  logic [1:0] FlagW;

  // Datapath selects
  logic       AdrSrc;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ResultSrc;
  logic [1:0] ALUControl;
  logic [1:0] RegSrc;
  logic [1:0] ImmSrc;

  logic       illegal;

  modport master (
    input  Op, Funct, Rd, mem_ready,
    output IRWrite, NextPC, Branch, PCs, RegW, MemW, FlagW,
    output AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, RegSrc, ImmSrc,
    output illegal
  );

  modport slave (
    output Op, Funct, Rd, mem_ready,
    input  IRWrite, NextPC, Branch, PCs, RegW, MemW, FlagW,
    input  AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUControl, RegSrc, ImmSrc,
    input  illegal
  );

endinterface

// File: rtl/mc_alu_decoder.sv
// ---------------------------------------------------------------------------
// mc_alu_decoder
// Combinational ALU decoder.
//   Funct      in  6  [5]=I, [4:1]=cmd, [0]=S
//   ALUOp      in  1  0: force ADD (address / PC arithmetic), 1: decode cmd
//   ALUControl out 2  ALU operation
//   FlagW      out 2  raw flag-write request, [1]=NZ, [0]=CV
// ---------------------------------------------------------------------------
module mc_alu_decoder
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] Funct,
  input  logic       ALUOp,
  output logic [1:0] ALUControl,
  output logic [1:0] FlagW
);

  logic [3:0] cmd;
  logic       s_bit;
  logic       arith;
  logic       unused_ibit;

  assign cmd         = Funct[4:1];
  assign s_bit       = Funct[0];
  assign unused_ibit = Funct[5];

  // Flags only update when the ALU runs a data-processing command with S set;
  // carry/overflow are meaningful only for the arithmetic commands.
  always_comb begin
    ALUControl = ALU_ADD;
    FlagW      = 2'b00;
    arith      = 1'b0;
    if (ALUOp) begin
      case (cmd)
        CMD_ADD: begin
          ALUControl = ALU_ADD;
          arith      = 1'b1;
        end
        CMD_SUB: begin
          ALUControl = ALU_SUB;
          arith      = 1'b1;
        end
        CMD_AND: ALUControl = ALU_AND;
        CMD_ORR: ALUControl = ALU_ORR;
        default: ALUControl = ALU_ADD;
      endcase
      FlagW = {s_bit, s_bit & arith};
    end
  end

endmodule

// File: rtl/mc_control_fsm.sv
// ---------------------------------------------------------------------------
// mc_control_fsm
// Multicycle control unit. Sequences each instruction through a Moore FSM and
// drives the raw (ungated) write requests, PC strobes and datapath selects
// consumed by the conditional-logic block.
//   clk       in   1        system clock
//   reset     in   1        synchronous, active-high
//   bus       master       instruction fields, mem_ready, all control outputs
//   state_dbg out  STATE_W  current FSM state
// ---------------------------------------------------------------------------
module mc_control_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  mc_control_fsm_if.master    bus,
  output logic [STATE_W-1:0]  state_dbg
);

  state_t     state;
  state_t     next_state;

  logic       fetch_strobe;
  logic       branch_req;
  logic       regw_req;
  logic       memw_req;
  logic       alu_op;
  logic       illegal_req;
  logic       adr_src;
  logic       src_a;
  logic [1:0] src_b;
  logic [1:0] result_src;
  logic [1:0] alu_ctl;
  logic [1:0] flagw_req;
  logic       dp_ok;
  logic       rd_is_pc;

  // Data-processing instruction the datapath can execute
  assign dp_ok    = cmd_supported(bus.Funct[4:1]);
  assign rd_is_pc = (bus.Rd == 4'd15);

  // State register; reset wins over any transition so an instruction in
  // flight is abandoned at the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_FETCH;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. The memory states wait on mem_ready; DECODE dispatches
  // on the instruction class and sends anything unsupported back to FETCH.
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (bus.mem_ready) next_state = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_MEM: next_state = S_MEMADR;
          OP_DP: begin
            if (!dp_ok)           next_state = S_FETCH;
            else if (bus.Funct[5]) next_state = S_EXECI;
            else                   next_state = S_EXECR;
          end
          OP_BR:   next_state = S_BRANCH;
          default: next_state = S_FETCH;
        endcase
      end
      S_MEMADR: next_state = bus.Funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.mem_ready) next_state = S_MEMWB;
      S_MEMWR:  if (bus.mem_ready) next_state = S_FETCH;
      S_MEMWB:  next_state = S_FETCH;
      S_EXECR:  next_state = S_ALUWB;
      S_EXECI:  next_state = S_ALUWB;
      S_ALUWB:  next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  // Moore outputs per state. FETCH's IR/PC strobe follows mem_ready so it
  // fires only on the cycle the fetch is accepted, never during a stall.
  always_comb begin
    fetch_strobe = 1'b0;
    branch_req   = 1'b0;
    regw_req     = 1'b0;
    memw_req     = 1'b0;
    alu_op       = 1'b0;
    illegal_req  = 1'b0;
    adr_src      = ADR_PC;
    src_a        = SRCA_RN;
    src_b        = SRCB_RM;
    result_src   = RES_ALUOUT;
    case (state)
      S_FETCH: begin
        adr_src      = ADR_PC;
        src_a        = SRCA_PC;
        src_b        = SRCB_FOUR;
        result_src   = RES_ALURESULT;
        fetch_strobe = bus.mem_ready;
      end
      S_DECODE: begin
        src_a       = SRCA_PC;
        src_b       = SRCB_FOUR;
        result_src  = RES_ALURESULT;
        illegal_req = (bus.Op == OP_ILL) || ((bus.Op == OP_DP) && !dp_ok);
      end
      S_MEMADR: begin
        src_a = SRCA_RN;
        src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        adr_src    = ADR_ALUOUT;
        result_src = RES_ALUOUT;
      end
      S_MEMWB: begin
        result_src = RES_READDATA;
        regw_req   = 1'b1;
      end
      S_MEMWR: begin
        adr_src  = ADR_ALUOUT;
        memw_req = 1'b1;
      end
      S_EXECR: begin
        src_a  = SRCA_RN;
        src_b  = SRCB_RM;
        alu_op = 1'b1;
      end
      S_EXECI: begin
        src_a  = SRCA_RN;
        src_b  = SRCB_IMM;
        alu_op = 1'b1;
      end
      S_ALUWB: begin
        result_src = RES_ALUOUT;
        regw_req   = 1'b1;
      end
      S_BRANCH: begin
        src_a      = SRCA_RN;
        src_b      = SRCB_IMM;
        result_src = RES_ALURESULT;
        branch_req = 1'b1;
      end
      default: ;
    endcase
  end

  mc_alu_decoder u_alu_decoder (
    .Funct      (bus.Funct),
    .ALUOp      (alu_op),
    .ALUControl (alu_ctl),
    .FlagW      (flagw_req)
  );

  // Every request that changes architectural state is suppressed while reset
  // is high, so an aborted instruction cannot leave a partial write behind.
  assign bus.IRWrite = fetch_strobe & ~reset;
  assign bus.NextPC  = fetch_strobe & ~reset;
  assign bus.Branch  = branch_req & ~reset;
  assign bus.RegW    = regw_req & ~reset;
  assign bus.MemW    = memw_req & ~reset;
  assign bus.FlagW   = reset ? 2'b00 : flagw_req;
  assign bus.PCs     = (branch_req | (regw_req & rd_is_pc)) & ~reset;
  assign bus.illegal = illegal_req & ~reset;

  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ResultSrc  = result_src;
  assign bus.ALUControl = alu_ctl;

  // Register-address and immediate-format selects depend only on the class
  assign bus.RegSrc = {(bus.Op == OP_MEM), (bus.Op == OP_BR)};
  assign bus.ImmSrc = bus.Op;

  assign state_dbg = STATE_W'(state);

endmodule
